ssd_scan: RTL
=============

# ssd_scan

Four-digit time-multiplexed display scanner that sits directly upstream of the 4-bit-to-7-segment decoder. It holds a 16-bit value, one hex nibble per digit, and steps through the digits at a programmable refresh rate. In each slot it presents that digit's nibble on `nibble`, which drives the decoder's `in`, and drives the matching active-low digit enable. New values are double-buffered and committed only at a frame boundary, so a partly updated frame is never displayed.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range is 1 and above.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `load` input 1: single-cycle strobe that captures `value` into the shadow register.
- `value` input 16: display value. `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `lzb` input 1: leading-zero blank enable; level-sensitive, sampled combinationally.
- `nibble` output 4: nibble of the currently selected digit, sent to the decoder `in`.
- `an` output 4: digit enables, active-low, one-hot-low or all-high when blanked.
- `pending` output 1: high while a loaded value is waiting for commit.

## Operation
**Registers**
- `cnt`: prescaler, width `max(1,$clog2(PRESCALE))`.
- `sel`: 2-bit digit index.
- `shadow`: 16 bits.
- `disp`: 16 bits.
- `pending`: 1 bit.

**Prescaler and digit select**
- `tick = (cnt == PRESCALE-1)`.
- On `tick`, `cnt` goes to 0; otherwise `cnt` increments.
- With `PRESCALE=1`, `tick` is high every cycle.
- On `tick`, `sel` increments modulo 4 (3→0 wraps); otherwise it holds.

**Load and commit**
- A frame boundary is the cycle with `tick && sel==3`.
- On `load`: `shadow <= value` and `pending <= 1`. This applies in any cycle, including repeated loads; the last load wins.
- On a frame boundary with `pending==1`: `disp <= shadow` (the pre-edge value) and `pending <= 0`.
- Simultaneous `load` and commit in the same cycle:
  - `disp` takes the old `shadow`.
  - `shadow` takes the new `value`.
  - `pending` stays 1.
  - The new value commits at the next frame boundary.

**Outputs** (combinational from registers)
- `nibble = disp[4*sel +: 4]`.
- `an = ~(4'b0001 << sel)` unless the selected digit is blanked, in which case `an = 4'b1111`. `nibble` is still driven when blanked.
- Blank rule, applied only when `lzb==1`:
  - Digit 3 blanks if `disp[15:12]==0`.
  - Digit 2 blanks if `disp[15:8]==0`.
  - Digit 1 blanks if `disp[15:4]==0`.
  - Digit 0 is never blanked.
- No state machine beyond the `sel` ring, which holds states D0→D1→D2→D3→D0.

## Timing
- Reset (async assert, released synchronously to `clk` by the system):
  - `cnt=0`, `sel=0`, `shadow=0`, `disp=0`, `pending=0`.
  - So `an=4'b1110`, `nibble=0`, `pending=0`.
- Each digit slot lasts exactly `PRESCALE` cycles; a frame lasts `4*PRESCALE` cycles.
- After reset, `sel` first changes on the edge after cycle `PRESCALE-1`.
- `pending` rises on the edge that samples `load`.
- Commit latency runs from the `load` edge to the next frame-boundary edge: between 1 and `4*PRESCALE` cycles.
- `disp` changes only on a frame-boundary edge, so `sel` is 0 in the first cycle that shows the new value.
- `an` and `nibble` change only on `tick` or commit edges. Change on `lzb` takes effect combinationally, with no registering.
- Reset asserted mid-frame or while pending: all state clears immediately, and the uncommitted load is discarded.

## Test plan
1. **Reset values.** Assert `rst_n=0` mid-scan with `PRESCALE=4` → `an=1110`, `nibble=0`, `pending=0` immediately, before any clock edge.
2. **Scan sequence.** `PRESCALE=4`, `lzb=0`, load `0x1234`, wait one frame → `an` cycles `1110, 1101, 1011, 0111`, each for 4 cycles, with `nibble` showing `4, 3, 2, 1`.
3. **Deferred commit.** Load `0xABCD` while `sel=1` → `pending=1` and `disp` unchanged until the boundary edge. The next cycle shows `sel=0`, `nibble=D`, `pending=0`.
4. **Leading-zero blanking.** Load `0x0042`, `lzb=1` → slots 3 and 2 show `an=1111`, slots 1 and 0 show 4 and 2. Load `0x0000` → only digit 0 is enabled, showing 0.
5. **Load on boundary.**
   - Load `0x1111` mid-frame.
   - Then pulse `load` with `0x2222` exactly on the boundary cycle.
   - Required: the next frame displays `1111` with `pending=1`, and the frame after displays `2222` with `pending=0`.
6. **`PRESCALE=1`.** `sel` advances every cycle and a frame is 4 cycles. A load before the boundary commits within 4 cycles.

Source files
------------

// File: rtl/ssd_scan.sv
// ssd_scan: four-digit time-multiplexed display scanner feeding a 4-bit to
// 7-segment decoder. It holds a 16-bit value (one hex nibble per digit),
// steps through the digits every PRESCALE clocks, and double-buffers new
// values so that a frame is never shown partly updated.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   load     single-cycle strobe: capture value into the shadow register
//   value    [15:0] display value; [3:0] is digit 0 (rightmost)
//   lzb      leading-zero blank enable (combinational effect)
//   nibble   [3:0] nibble of the selected digit, to the decoder input
//   an       [3:0] active-low digit enables (all high when blanked)
//   pending  high while a loaded value is waiting for a frame boundary
//
// Handshake: load is a bare strobe with no ready. Every cycle it is high is
// accepted; the most recent value loaded before a frame boundary commits.
module ssd_scan #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lzb,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   shadow;
  logic [15:0]   disp;
  logic          tick;
  logic          frame_end;
  logic          blank;

  assign tick      = (cnt == CW'(PRESCALE - 1));
  assign frame_end = tick && (sel == 2'd3);

  // Prescaler and digit ring. The ring is the only sequencing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow/display double buffer. The load assignment comes last so that a
  // load landing on the commit cycle keeps pending set for the next frame,
  // while disp still takes the pre-edge shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= 16'h0000;
      disp    <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero blanking: a digit blanks only if it and every digit to its
  // left are zero. Digit 0 always shows so a zero value still displays "0".
  always_comb begin
    blank = 1'b0;
    if (lzb) begin
      case (sel)
        2'd3:    blank = (disp[15:12] == 4'h0);
        2'd2:    blank = (disp[15:8]  == 8'h00);
        2'd1:    blank = (disp[15:4]  == 12'h000);
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    nibble = disp[{sel, 2'b00} +: 4];
    an     = blank ? 4'b1111 : ~(4'b0001 << sel);
  end

endmodule
